kernel_pp: RTL

KERNEL_PP -- requirements
Module: kernel_pp

---
 rtl/kernel_pp.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/kernel_pp.sv
// kernel_pp: ping-pong kernel buffer that packs a narrow beat stream into wide words
// and replays each filled bank a configurable number of passes.
module kernel_pp #(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter logic [CFG_AWIDTH-1:0] CFG_KER_WR = 5'd2,
    parameter logic [CFG_AWIDTH-1:0] CFG_KER_RD = 5'd3,
    parameter int STR_KER_WIDTH = 16,
    parameter int GROUP_NB = 4,
    parameter int KER_WIDTH = 16,
    parameter int DEPTH_NB = 1,
    parameter int MEM_AWIDTH = 8,
    localparam int OUT_W = GROUP_NB*KER_WIDTH*DEPTH_NB
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CFG_DWIDTH-1:0]    cfg_data,
    input  logic [CFG_AWIDTH-1:0]    cfg_addr,
    input  logic                     cfg_valid,
    input  logic [STR_KER_WIDTH-1:0] str_ker,
    input  logic                     str_ker_val,
    output logic                     str_ker_rdy,
    output logic [OUT_W-1:0]         kernel,
    output logic                     kernel_val,
    input  logic                     kernel_rdy,
    output logic                     kernel_last,
    output logic [1:0]               bank_full
);
    localparam int R = OUT_W / STR_KER_WIDTH;
    localparam int BCW = R > 1 ? $clog2(R) : 1;
    localparam int DEPTH = 2**MEM_AWIDTH;

    typedef enum logic {W_IDLE, W_FILL} wr_state_t;
    typedef enum logic {R_IDLE, R_RUN} rd_state_t;

    wr_state_t wr_st;
    rd_state_t rd_st;
    logic [OUT_W-1:0] mem [2*DEPTH];
    logic [OUT_W-1:0] pack, wdata;
    logic [MEM_AWIDTH-1:0] wr_end, wr_end_w, wr_addr, rd_end, rd_end_w, rd_addr;
    logic [15:0] rd_rep, rd_rep_w, pass_cnt;
    logic [BCW-1:0] beat_cnt;
    logic wr_sel, rd_sel, wr_arm, rd_arm, iss_done;
    logic cfg_wr, cfg_rd, acc, word_done, wr_done, rd_done, issue, at_end;
    logic unused_cfg;

    assign unused_cfg = ^cfg_data;
    assign cfg_wr = cfg_valid && cfg_addr == CFG_KER_WR;
    assign cfg_rd = cfg_valid && cfg_addr == CFG_KER_RD;
    assign str_ker_rdy = wr_st == W_FILL;
    assign acc = str_ker_rdy && str_ker_val;
    assign word_done = acc && beat_cnt == BCW'(R-1);
    assign wr_done = word_done && wr_addr == wr_end_w;
    assign issue = rd_st == R_RUN && !iss_done && (!kernel_val || kernel_rdy);
    assign at_end = rd_addr == rd_end_w && pass_cnt == rd_rep_w;
    assign rd_done = rd_st == R_RUN && kernel_val && kernel_rdy && kernel_last;

    // The final beat bypasses the pack register so the word lands in the same cycle.
    always_comb begin
        wdata = pack;
        wdata[OUT_W-STR_KER_WIDTH +: STR_KER_WIDTH] = str_ker;
    end

    always_ff @(posedge clk)
        if (word_done) mem[{wr_sel, wr_addr}] <= wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_st <= W_IDLE;
            wr_arm <= 1'b0;
            wr_sel <= 1'b0;
            wr_end <= '0;
            wr_end_w <= '0;
            wr_addr <= '0;
            beat_cnt <= '0;
            pack <= '0;
        end else begin
            if (cfg_wr) begin
                wr_end <= cfg_data[MEM_AWIDTH-1:0];
                wr_arm <= 1'b1;
            end
            if (wr_st == W_IDLE) begin
                if (wr_arm && !bank_full[wr_sel]) begin
                    wr_st <= W_FILL;
                    wr_end_w <= wr_end;
                    wr_addr <= '0;
                    beat_cnt <= '0;
                end
            end else if (acc) begin
                for (int k = 0; k < R; k++)
                    if (beat_cnt == BCW'(k)) pack[k*STR_KER_WIDTH +: STR_KER_WIDTH] <= str_ker;
                beat_cnt <= word_done ? '0 : beat_cnt + 1'b1;
                if (word_done) wr_addr <= wr_addr + 1'b1;
                if (wr_done) begin
                    wr_sel <= !wr_sel;
                    wr_st <= W_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_st <= R_IDLE;
            rd_arm <= 1'b0;
            rd_sel <= 1'b0;
            rd_end <= '0;
            rd_rep <= '0;
            rd_end_w <= '0;
            rd_rep_w <= '0;
            rd_addr <= '0;
            pass_cnt <= '0;
            iss_done <= 1'b0;
            kernel <= '0;
            kernel_val <= 1'b0;
            kernel_last <= 1'b0;
        end else begin
            if (cfg_rd) begin
                rd_end <= cfg_data[MEM_AWIDTH-1:0];
                rd_rep <= cfg_data[31:16];
                rd_arm <= 1'b1;
            end
            if (rd_st == R_IDLE) begin
                if (rd_arm && bank_full[rd_sel]) begin
                    rd_st <= R_RUN;
                    rd_end_w <= rd_end;
                    rd_rep_w <= rd_rep;
                    rd_addr <= '0;
                    pass_cnt <= '0;
                    iss_done <= 1'b0;
                end
            end else if (rd_done) begin
                rd_sel <= !rd_sel;
                rd_st <= R_IDLE;
            end
            // Read straight into the output register: one-cycle latency, no skid buffer.
            if (issue) begin
                kernel <= mem[{rd_sel, rd_addr}];
                kernel_val <= 1'b1;
                kernel_last <= at_end;
                iss_done <= at_end;
                rd_addr <= rd_addr == rd_end_w ? '0 : rd_addr + 1'b1;
                pass_cnt <= rd_addr == rd_end_w ? pass_cnt + 1'b1 : pass_cnt;
            end else if (kernel_rdy) begin
                kernel_val <= 1'b0;
                kernel_last <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_full <= '0;
        end else begin
            if (wr_done) bank_full[wr_sel] <= 1'b1;
            if (rd_done) bank_full[rd_sel] <= 1'b0;
        end
    end
endmodule
